rom_load_ctrl: RTL
==================

# rom_load_ctrl

Sequences the HPS ROM download stream into the game and audio boards' ROM BRAMs. It decodes each downloaded byte's address into a target ROM region and drives a single shared memory-write request/acknowledge port. It back-pressures the HPS through the wait line and holds the CPUs in reset across the load. It sits between hps_io's ioctl outputs and the rom_init inputs of mylstar_board / ma216_board.

## Interface
- ACK_TIMEOUT, 15: max cycles to wait for mem_ack before dropping a byte
- HOLD_EXTRA, 255: cycles cpu_hold stays high after the load finishes
- clk_sys  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- dl_active  in  1  ROM download in progress (ioctl_download & index 0)
- dl_wr  in  1  single-cycle byte strobe
- dl_addr  in  25  byte address in the download image
- dl_data  in  8  byte value
- dl_wait  out  1  back-pressure to hps_io
- mem_req  out  1  write request, held until ack or timeout
- mem_sel  out  3  target region index (package constants)
- mem_addr  out  16  offset within region
- mem_data  out  8  byte to write
- mem_ack  in  1  single-cycle write accept
- cpu_hold  out  1  hold CPU/sound boards in reset
- load_done  out  1  sticky completion flag
- byte_count  out  25  bytes successfully written
- checksum  out  16  sum of written bytes mod 2^16
- err_flags  out  2  [0] out-of-map address seen, [1] ack timeout seen; sticky

## Operation
- Region map is fixed by the package: 0 CPU 0x00000–0x07FFF, 1 tiles 0x08000–0x0BFFF, 2 sprites 0x0C000–0x13FFF, 3 sound 0x14000–0x14FFF. mem_addr = dl_addr − base, truncated to 16 bits.
- Bytes at or above 0x15000: not written and not counted. They set err_flags[0] and cost one cycle in DECODE.
- FSM states: IDLE, DECODE, REQ, DONE_WAIT.
  - IDLE → DECODE on a byte available (skid slot or dl_wr).
  - DECODE: latch sel/addr/data. Go to REQ if in-map, else back to IDLE.
  - REQ: mem_req=1. On mem_ack, byte_count+1, checksum+=data, go to IDLE. After ACK_TIMEOUT cycles with no ack, set err_flags[1] and go to IDLE without counting.
  - DONE_WAIT: counting down HOLD_EXTRA. A dl_active rise returns the FSM to IDLE.
- Skid buffer: one entry. dl_wr arriving while the FSM is not in IDLE is stored there. dl_wait = skid full OR state ∈ {DECODE, REQ}.
- A dl_wr arriving while the skid is already full is a protocol violation. The byte is dropped and err_flags[1] is set.
- Load start, on a dl_active rise:
  - clear byte_count, checksum, err_flags and load_done
  - raise cpu_hold
- Load end, on dl_active low with the FSM in IDLE and the skid empty:
  - enter DONE_WAIT
  - after HOLD_EXTRA cycles, drop cpu_hold, set load_done, return to IDLE
- Simultaneous dl_wr and a dl_active fall: the byte is still processed. The end condition is evaluated only once the FSM is idle.

## Timing
- Reset values: dl_wait 0, mem_req 0, mem_sel 0, mem_addr 0, mem_data 0, cpu_hold 1, load_done 0, byte_count 0, checksum 0, err_flags 0. FSM in IDLE, skid empty.
- cpu_hold is 1 out of reset so the boards stay held until the first load completes.
- Latency: dl_wr in cycle N → DECODE N+1 → mem_req high N+2. dl_wait is high from N+1 through the ack cycle.
- Best-case throughput is one byte per 3 cycles plus ack latency.
- mem_ack is honoured only while mem_req=1. Acks at other times are ignored.
- mem_req drops in the cycle after the ack. mem_sel, mem_addr and mem_data are stable for the whole request.
- Reset mid-load: everything returns to reset values immediately. Any in-flight request is abandoned, with mem_req low the next cycle.

## Structure
- Package rom_load_pkg holds:
  - region index constants (REG_CPU, REG_TILE, REG_SPR, REG_SND)
  - base/limit arrays and MAP_END = 0x15000
  - the state enum
- One sub-module, rom_region_decode: a combinational addr → {valid, sel, offset} lookup.
- The FSM, skid buffer, counters and hold timer live in rom_load_ctrl.

## Test plan
- Single byte 0x5A at 0x00010 with ack after 2 cycles: mem_sel=0, mem_addr=0x0010, mem_data=0x5A. byte_count=1, checksum=0x005A.
- Byte at 0x0C004 → mem_sel=2, mem_addr=0x0004. Byte at 0x15000 → no mem_req, err_flags=01, byte_count unchanged.
- Back-to-back dl_wr on consecutive cycles: second byte held in the skid, dl_wait high. Both bytes are written in order.
- mem_ack never asserted: mem_req drops after exactly 15 cycles, err_flags[1]=1, byte_count=0.
- Full 0x15000-byte load, then dl_active fall: cpu_hold falls exactly 255 cycles later, load_done=1, byte_count=0x15000.
- reset asserted while in REQ: next cycle mem_req=0, cpu_hold=1, byte_count=0. A fresh load afterwards completes normally.

Source files
------------

// File: rtl/rom_load_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : rom_load_pkg                                             |
// | Description : Shared constants for the ROM download controller: the    |
// |               download image region map, region indices and the        |
// |               controller state encoding.                               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package rom_load_pkg;

    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 8;
    localparam int SEL_W       = 3;
    localparam int OFFS_W      = 16;
    localparam int NUM_REGIONS = 4;

    // Target region indices as seen on mem_sel.
    localparam logic [SEL_W-1:0] REG_CPU  = 3'd0;
    localparam logic [SEL_W-1:0] REG_TILE = 3'd1;
    localparam logic [SEL_W-1:0] REG_SPR  = 3'd2;
    localparam logic [SEL_W-1:0] REG_SND  = 3'd3;

    // First address past the last mapped byte of the download image.
    localparam logic [ADDR_W-1:0] MAP_END = 25'h15000;

    // Region table, element 0 is the rightmost entry. Limits are exclusive.
    localparam logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE =
        {25'h14000, 25'h0C000, 25'h08000, 25'h00000};
    localparam logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_LIMIT =
        {MAP_END,   25'h14000, 25'h0C000, 25'h08000};
    localparam logic [NUM_REGIONS-1:0][SEL_W-1:0] REGION_SEL =
        {REG_SND, REG_SPR, REG_TILE, REG_CPU};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_REQ       = 2'd2,
        ST_DONE_WAIT = 2'd3
    } state_t;

endpackage : rom_load_pkg
`default_nettype wire

// File: rtl/rom_region_decode.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rom_region_decode                                        |
// | Description : Combinational lookup of a download byte address into a   |
// |               target ROM region and the offset within that region.     |
// | Ports       : addr   - byte address in the download image              |
// |               valid  - address falls inside one of the mapped regions  |
// |               sel    - region index (0 when not valid)                 |
// |               offset - addr minus region base, low 16 bits             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rom_region_decode
    import rom_load_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [SEL_W-1:0]  sel,
    output logic [OFFS_W-1:0] offset
);

    logic [ADDR_W-1:0] rel;

    // One unsigned compare per region: (addr - base) wraps to a huge value
    // for addresses below the base, so rel < size covers both bounds.
    always_comb begin
        valid  = 1'b0;
        sel    = '0;
        offset = '0;
        rel    = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            rel = addr - REGION_BASE[i];
            if (rel < (REGION_LIMIT[i] - REGION_BASE[i])) begin
                valid  = 1'b1;
                sel    = REGION_SEL[i];
                offset = rel[OFFS_W-1:0];
            end
        end
    end

endmodule : rom_region_decode
`default_nettype wire

// File: rtl/rom_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rom_load_ctrl                                            |
// | Description : Sequences the HPS ROM download byte stream into the ROM  |
// |               BRAMs over one shared write request/acknowledge port,    |
// |               back-pressures the HPS and holds the CPUs in reset       |
// |               across the load.                                         |
// | Ports       : clk_sys, reset          - clock, sync active-high reset  |
// |               dl_active/dl_wr/dl_addr/dl_data - download stream in     |
// |               dl_wait                 - back-pressure to hps_io        |
// |               mem_req/sel/addr/data, mem_ack - ROM write port          |
// |               cpu_hold, load_done     - board hold and completion      |
// |               byte_count, checksum, err_flags - load statistics        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int HOLD_EXTRA  = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    output logic              dl_wait,
    output logic              mem_req,
    output logic [SEL_W-1:0]  mem_sel,
    output logic [OFFS_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W-1:0] byte_count,
    output logic [15:0]       checksum,
    output logic [1:0]        err_flags
);

    localparam int TMR_W = 16;

    state_t              state_q,      state_d;
    logic                skid_full_q,  skid_full_d;
    logic [ADDR_W-1:0]   skid_addr_q,  skid_addr_d;
    logic [DATA_W-1:0]   skid_data_q,  skid_data_d;
    logic [ADDR_W-1:0]   cur_addr_q,   cur_addr_d;
    logic [DATA_W-1:0]   cur_data_q,   cur_data_d;
    logic [SEL_W-1:0]    mem_sel_q,    mem_sel_d;
    logic [OFFS_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q,   mem_data_d;
    logic [TMR_W-1:0]    tmr_q,        tmr_d;
    logic                cpu_hold_q,   cpu_hold_d;
    logic                load_done_q,  load_done_d;
    logic                loading_q,    loading_d;
    logic [ADDR_W-1:0]   byte_count_q, byte_count_d;
    logic [15:0]         checksum_q,   checksum_d;
    logic [1:0]          err_q,        err_d;
    logic                dl_active_q;

    logic                dec_valid;
    logic [SEL_W-1:0]    dec_sel;
    logic [OFFS_W-1:0]   dec_offset;
    logic                dl_rise;

    rom_region_decode u_decode (
        .addr   (cur_addr_q),
        .valid  (dec_valid),
        .sel    (dec_sel),
        .offset (dec_offset)
    );

    assign dl_rise = dl_active & ~dl_active_q;

    always_comb begin
        state_d      = state_q;
        skid_full_d  = skid_full_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        cur_addr_d   = cur_addr_q;
        cur_data_d   = cur_data_q;
        mem_sel_d    = mem_sel_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        tmr_d        = tmr_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = load_done_q;
        loading_d    = loading_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        err_d        = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // A pending byte always wins over the end-of-load check, so a
                // byte arriving with the dl_active fall is still written.
                if (skid_full_q) begin
                    cur_addr_d = skid_addr_q;
                    cur_data_d = skid_data_q;
                    state_d    = ST_DECODE;
                end else if (dl_wr) begin
                    cur_addr_d = dl_addr;
                    cur_data_d = dl_data;
                    state_d    = ST_DECODE;
                end else if (loading_q && !dl_active) begin
                    tmr_d     = TMR_W'(HOLD_EXTRA - 1);
                    loading_d = 1'b0;
                    state_d   = ST_DONE_WAIT;
                end
            end
            ST_DECODE: begin
                if (dec_valid) begin
                    mem_sel_d  = dec_sel;
                    mem_addr_d = dec_offset;
                    mem_data_d = cur_data_q;
                    tmr_d      = TMR_W'(ACK_TIMEOUT - 1);
                    state_d    = ST_REQ;
                end else begin
                    err_d[0] = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    byte_count_d = byte_count_q + ADDR_W'(1);
                    checksum_d   = checksum_q + {8'd0, mem_data_q};
                    state_d      = ST_IDLE;
                end else if (tmr_q == '0) begin
                    err_d[1] = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_DONE_WAIT: begin
                if (tmr_q == '0) begin
                    cpu_hold_d  = 1'b0;
                    load_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Skid slot: drained by IDLE (refilled in the same cycle if a new byte
        // lands), filled while busy, and a byte hitting a full slot is lost.
        if (state_q == ST_IDLE && skid_full_q) begin
            skid_full_d = dl_wr;
            skid_addr_d = dl_addr;
            skid_data_d = dl_data;
        end else if (dl_wr && state_q != ST_IDLE) begin
            if (skid_full_q) begin
                err_d[1] = 1'b1;
            end else begin
                skid_full_d = 1'b1;
                skid_addr_d = dl_addr;
                skid_data_d = dl_data;
            end
        end

        // Load start overrides everything above, including a hold countdown.
        if (dl_rise) begin
            byte_count_d = '0;
            checksum_d   = '0;
            err_d        = '0;
            load_done_d  = 1'b0;
            cpu_hold_d   = 1'b1;
            loading_d    = 1'b1;
            if (state_q == ST_DONE_WAIT) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            skid_full_q  <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            cur_addr_q   <= '0;
            cur_data_q   <= '0;
            mem_sel_q    <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            tmr_q        <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            loading_q    <= 1'b0;
            byte_count_q <= '0;
            checksum_q   <= '0;
            err_q        <= '0;
            dl_active_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            skid_full_q  <= skid_full_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            cur_addr_q   <= cur_addr_d;
            cur_data_q   <= cur_data_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            tmr_q        <= tmr_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            loading_q    <= loading_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            err_q        <= err_d;
            dl_active_q  <= dl_active;
        end
    end

    assign mem_req    = (state_q == ST_REQ);
    assign dl_wait    = skid_full_q | (state_q == ST_DECODE) | (state_q == ST_REQ);
    assign mem_sel    = mem_sel_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;
    assign err_flags  = err_q;

endmodule : rom_load_ctrl
`default_nettype wire
